// File: rtl/chan_pkg.sv
// Shared definitions for the channelizer AXI-stream family: framer FSM
// encoding and the {tlast, tdata} beat carried through skid buffers and FIFOs.
package chan_pkg;

  localparam int CHAN_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } framer_state_t;

  typedef struct packed {
    logic                       tlast;
    logic [CHAN_DATA_WIDTH-1:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/axi_framer_tx_if.sv
// AXI-stream bundle (valid/ready/data/last) with master and slave views.
interface axi_framer_tx_if #(
  parameter int DATA_WIDTH = chan_pkg::CHAN_DATA_WIDTH
);

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);

endinterface

// File: rtl/axi_skid_2.sv
// Two-entry registered AXI-stream slice. The output entry drives the bus
// directly; the spare entry absorbs one beat while the sink stalls. The
// caller gates push with a ready derived from occ_next, so a push into a
// full slice never happens.
module axi_skid_2
  import chan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  axis_beat_t push_beat,
  input  logic       pop_ready,
  output logic       out_valid,
  output axis_beat_t out_beat,
  output logic [1:0] occ_next
);

  logic [1:0] occ_q;
  axis_beat_t out_q;
  axis_beat_t spare_q;
  logic       pop;

  // Pop decision and next occupancy (push+pop together keeps occupancy)
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pop      = (occ_q != 2'd0) && pop_ready;
    occ_next = occ_q;
    case ({push, pop})
      2'b10:   occ_next = occ_q + 2'd1;
      2'b01:   occ_next = occ_q - 2'd1;
      default: ;
    endcase
  end

  // Entry storage: fill output entry first, spill to spare, refill from spare
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
    if (rst) begin
      // NOTE: the data entries are reset too (not just occupancy) so the bus reads all-zero during reset.
      occ_q   <= 2'd0;
      out_q   <= '0;
      spare_q <= '0;
    end else begin
      occ_q <= occ_next;
      case (occ_q)
        2'd0: if (push) out_q <= push_beat;
        2'd1: begin
          if (push && pop) out_q   <= push_beat;
          else if (push)   spare_q <= push_beat;
        end
        default: if (pop) out_q <= spare_q;
      endcase
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_beat  = out_q;

endmodule

// File: rtl/axi_framer_tx.sv
// Transmit framer: cuts an unframed sample stream into fixed-length packets
// with tlast on the final beat. A packet starts only while the downstream
// almost_full is low; once started it always completes. Output goes through
// a 2-entry skid so both sides run at full rate with registered handshakes.
module axi_framer_tx
  import chan_pkg::*;
#(
  parameter int DATA_WIDTH = CHAN_DATA_WIDTH,
  parameter int LEN_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 async_reset,
  input  logic [LEN_WIDTH-1:0] frame_len,
  axi_framer_tx_if.slave       s_axis,
  input  logic                 almost_full,
  axi_framer_tx_if.master      m_axis,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_count
);

  framer_state_t         state_q, state_next;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  s_ready_q;
  logic                  push;
  logic                  push_last;
  logic [DATA_WIDTH-1:0] in_data;
  axis_beat_t            push_beat;
  axis_beat_t            out_beat;
  logic                  out_valid;
  logic [1:0]            occ_next;
  logic                  unused_s_tlast;

  // The input stream is unframed; its tlast carries no meaning here.
  assign unused_s_tlast = s_axis.tlast;

  assign in_data   = s_axis.tdata;
  assign push      = s_ready_q && s_axis.tvalid;
  assign push_last = (beat_cnt_q == '0);
  assign push_beat = '{tlast: push_last, tdata: in_data};

  // Next-state: start on almost_full low, finish on the tagged-last accept
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (!almost_full) state_next = SEND;
      SEND:    if (push && push_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) state_q <= IDLE;
    else             state_q <= state_next;
  end

  // Beat counter (frame_len latched at start, 0 treated as 1) and registered
  // input ready, computed from next-cycle state and skid occupancy
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      beat_cnt_q <= '0;
      s_ready_q  <= 1'b0;
    end else begin
      s_ready_q <= (state_next == SEND) && (occ_next != 2'd2);
      if (state_q == IDLE && !almost_full)
        beat_cnt_q <= (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
      else if (push)
        beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset)
      frame_count <= '0;
    else if (out_valid && m_axis.tready && out_beat.tlast)
      frame_count <= frame_count + CNT_WIDTH'(1);
  end

  axi_skid_2 u_skid (
    .clk       (clk),
    .rst       (async_reset),
    .push      (push),
    .push_beat (push_beat),
    .pop_ready (m_axis.tready),
    .out_valid (out_valid),
    .out_beat  (out_beat),
    .occ_next  (occ_next)
  );

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_beat.tdata;
  assign m_axis.tlast  = out_beat.tlast;
  assign busy          = (state_q == SEND);

endmodule

// File: tb/tb_axi_framer_tx.sv
// Self-checking bench for axi_framer_tx: scoreboard of tagged input beats,
// table of frame-length / sink-behaviour rows, plus hand-written sequences
// for start latency, almost_full gating and mid-frame reset.
module tb_axi_framer_tx;
  import chan_pkg::*;

  localparam int DW = 32;
  localparam int LW = 12;
  localparam int CW = 16;
  localparam int TIMEOUT = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] frame_len;
  logic          almost_full;
  logic          busy;
  logic [CW-1:0] frame_count;

  axi_framer_tx_if #(.DATA_WIDTH(DW)) s_if ();
  axi_framer_tx_if #(.DATA_WIDTH(DW)) m_if ();

  axi_framer_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .async_reset (rst),
    .frame_len   (frame_len),
    .s_axis      (s_if),
    .almost_full (almost_full),
    .m_axis      (m_if),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and model state
  logic [DW:0]   exp_q[$];
  int            rem = 0;
  int            model_len = 1;
  int            s_row_beats = 0;
  int            m_row_beats = 0;
  int            m_row_frames = 0;
  bit            sink_rand = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [DW-1:0] src_data = '0;
  logic [DW:0]   exp_beat;
  bit            s_acc, m_acc;

  // Monitor on negedge, drive source/sink #1 after posedge
  initial begin
    s_if.tvalid = 1'b1;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      s_acc = 1'b0;
      m_acc = 1'b0;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", m_if.tvalid, 1);
          check("stall_data", m_if.tdata, stall_data);
          check("stall_last", m_if.tlast, stall_last);
        end
        s_acc = s_if.tvalid && s_if.tready;
        m_acc = m_if.tvalid && m_if.tready;
        if (s_acc) begin
          if (rem == 0) rem = model_len;
          rem--;
          exp_q.push_back({rem == 0, s_if.tdata});
          s_row_beats++;
        end
        if (m_acc) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {m_if.tlast, m_if.tdata}, 64'hdead);
          end else begin
            exp_beat = exp_q.pop_front();
            check("beat", {m_if.tlast, m_if.tdata}, exp_beat);
          end
          m_row_beats++;
          if (m_if.tlast) m_row_frames++;
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        stall_data = m_if.tdata;
        stall_last = m_if.tlast;
      end
      @(posedge clk);
      #1;
      if (s_acc) src_data = src_data + 32'h0101_0001;
      s_if.tdata  = src_data;
      m_if.tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_row();
    s_row_beats  = 0;
    m_row_beats  = 0;
    m_row_frames = 0;
  endtask

  // Run until n frames are out and drained; hold off new frames via
  // almost_full once the last frame of the row has started.
  task automatic wait_frames(input int n);
    int cyc;
    cyc = 0;
    while (!(m_row_frames >= n && exp_q.size() == 0 && !m_if.tvalid) && cyc < TIMEOUT) begin
      step();
      cyc++;
      if (s_row_beats >= (n - 1) * model_len + 1) almost_full = 1'b1;
    end
    check("frames_done_in_time", cyc < TIMEOUT, 1);
  endtask

  task automatic run_frames(input int len, input int n, input bit rnd);
    frame_len   = LW'(len);
    model_len   = (len == 0) ? 1 : len;
    sink_rand   = rnd;
    clear_row();
    almost_full = 1'b0;
    wait_frames(n);
  endtask

  typedef struct {
    int len;
    int nframes;
    bit rnd;
    int exp_beats;
  } row_t;

  row_t rows[4];
  int   tb_total = 0;
  int   cyc;

  initial begin
    rows[0] = '{len: 0, nframes: 5,  rnd: 1'b0, exp_beats: 5};
    rows[1] = '{len: 5, nframes: 20, rnd: 1'b1, exp_beats: 100};
    rows[2] = '{len: 1, nframes: 3,  rnd: 1'b1, exp_beats: 3};
    rows[3] = '{len: 7, nframes: 2,  rnd: 1'b1, exp_beats: 14};

    frame_len   = LW'(4);
    model_len   = 4;
    almost_full = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_m_tvalid", m_if.tvalid, 0);
    check("reset_s_tready", s_if.tready, 0);
    check("reset_m_tdata", m_if.tdata, 0);
    check("reset_m_tlast", m_if.tlast, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_count", frame_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // almost_full held from reset: nothing starts
    repeat (4) step();
    @(negedge clk);
    check("af_hold_s_tready", s_if.tready, 0);
    check("af_hold_m_tvalid", m_if.tvalid, 0);
    check("af_hold_busy", busy, 0);

    // Drop almost_full: first tready one cycle later, then 4-beat frames
    step();
    clear_row();
    almost_full = 1'b0;
    @(negedge clk);
    check("start_gap_tready", s_if.tready, 0);
    @(negedge clk);
    check("start_tready", s_if.tready, 1);
    check("start_m_tvalid", m_if.tvalid, 0);
    @(negedge clk);
    check("latency_m_tvalid", m_if.tvalid, 1);
    check("first_tlast", m_if.tlast, 0);
    check("fc_before_first", frame_count, 0);
    repeat (3) @(negedge clk);
    check("gap_s_tready", s_if.tready, 0);
    check("gap_busy", busy, 0);
    check("gap_m_tlast", m_if.tlast, 1);
    @(negedge clk);
    check("resume_s_tready", s_if.tready, 1);
    check("resume_busy", busy, 1);
    check("fc_after_first", frame_count, 1);
    wait_frames(2);
    tb_total += 2;
    check("len4_beats", m_row_beats, 8);
    check("len4_frame_count", frame_count, 2);

    // almost_full rises after beat 2 of 8 (and frame_len changes mid-frame)
    frame_len = LW'(8);
    model_len = 8;
    clear_row();
    almost_full = 1'b0;
    cyc = 0;
    while (s_row_beats < 2 && cyc < TIMEOUT) begin
      step();
      cyc++;
    end
    check("af_mid_reached_beat2", cyc < TIMEOUT, 1);
    almost_full = 1'b1;
    frame_len   = LW'(3);
    wait_frames(1);
    tb_total += 1;
    check("af_mid_out_beats", m_row_beats, 8);
    check("af_mid_in_beats", s_row_beats, 8);
    repeat (10) step();
    check("af_mid_no_new_frame", s_row_beats, 8);
    check("af_mid_idle_busy", busy, 0);
    run_frames(8, 1, 1'b0);
    tb_total += 1;
    check("af_release_beats", m_row_beats, 8);
    check("af_release_frame_count", frame_count, CW'(tb_total));

    // Table rows: length 0 boundary, random sink stalls, short frames
    foreach (rows[i]) begin
      run_frames(rows[i].len, rows[i].nframes, rows[i].rnd);
      tb_total += rows[i].nframes;
      check($sformatf("row%0d_beats", i), m_row_beats, rows[i].exp_beats);
      check($sformatf("row%0d_frames", i), m_row_frames, rows[i].nframes);
      check($sformatf("row%0d_frame_count", i), frame_count, CW'(tb_total));
    end

    // Reset at beat 3 of a 6-beat frame
    frame_len = LW'(6);
    model_len = 6;
    sink_rand = 1'b0;
    clear_row();
    almost_full = 1'b0;
    cyc = 0;
    while (s_row_beats < 3 && cyc < TIMEOUT) begin
      step();
      cyc++;
    end
    check("rst_mid_reached_beat3", cyc < TIMEOUT, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_m_tvalid", m_if.tvalid, 0);
    check("rst_mid_s_tready", s_if.tready, 0);
    check("rst_mid_m_tdata", m_if.tdata, 0);
    check("rst_mid_m_tlast", m_if.tlast, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_frame_count", frame_count, 0);
    exp_q.delete();
    rem = 0;
    tb_total = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_row();
    wait_frames(1);
    check("rst_restart_beats", m_row_beats, 6);
    check("rst_restart_frame_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
